// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
//   Shared definitions for the stack-access sequencer of the stack CPU.
//   - state_e       : sequencer FSM encoding
//   - stack_req_t   : stack-access bits kept for the life of one operation
//   - WORD_BYTES    : byte stride between adjacent stack slots
//   - opcode class match/mask pairs and op_class(), used by the control unit
//     to classify a 6-bit opcode before deriving read_reg1/read_reg2/write_reg
// -----------------------------------------------------------------------------
package stack_pkg;

  // Sequencer states. IDLE is the only state that accepts a new op.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP_A = 3'd1,
    ST_POP_B = 3'd2,
    ST_EXEC  = 3'd3,
    ST_PUSH  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Bits still needed after acceptance. The first pop is fully decided at
  // accept time (it selects POP_A versus EXEC), so only the second pop and
  // the push have to be carried through the sequence.
  typedef struct packed {
    logic pop_b;
    logic push;
  } stack_req_t;

  // One stack slot is one 32-bit word.
  localparam int unsigned WORD_BYTES = 4;

  // Opcode classes. A class matches when (opcode & MASK) == MATCH.
  localparam logic [5:0] OPC_ALU_MATCH     = 6'b000_000;
  localparam logic [5:0] OPC_ALU_MASK      = 6'b111_000;
  localparam logic [5:0] OPC_IMM_MATCH     = 6'b001_000;
  localparam logic [5:0] OPC_IMM_MASK      = 6'b111_000;
  localparam logic [5:0] OPC_CMP_MATCH     = 6'b010_000;
  localparam logic [5:0] OPC_CMP_MASK      = 6'b111_100;
  localparam logic [5:0] OPC_BR_MATCH      = 6'b011_000;
  localparam logic [5:0] OPC_BR_MASK       = 6'b111_110;
  localparam logic [5:0] OPC_PUSH_MATCH    = 6'b100_000;
  localparam logic [5:0] OPC_POP_MATCH     = 6'b101_000;
  localparam logic [5:0] OPC_PUSH_PC_MATCH = 6'b110_000;
  localparam logic [5:0] OPC_POP_PC_MATCH  = 6'b111_000;
  localparam logic [5:0] OPC_EXACT_MASK    = 6'b111_111;

  typedef enum logic [3:0] {
    CLS_ALU,
    CLS_IMM,
    CLS_CMP,
    CLS_BR,
    CLS_PUSH,
    CLS_POP,
    CLS_PUSH_PC,
    CLS_POP_PC,
    CLS_NONE
  } op_class_e;

  // Classify an opcode. The stack-transfer classes are exact encodings, so
  // they are tested before the wide ALU/IMM ranges cannot shadow them (the
  // ranges do not overlap, but the order keeps that obvious).
  function automatic op_class_e op_class(input logic [5:0] opc);
    op_class_e cls;
    cls = CLS_NONE;
    if      ((opc & OPC_EXACT_MASK) == OPC_PUSH_MATCH)    cls = CLS_PUSH;
    else if ((opc & OPC_EXACT_MASK) == OPC_POP_MATCH)     cls = CLS_POP;
    else if ((opc & OPC_EXACT_MASK) == OPC_PUSH_PC_MATCH) cls = CLS_PUSH_PC;
    else if ((opc & OPC_EXACT_MASK) == OPC_POP_PC_MATCH)  cls = CLS_POP_PC;
    else if ((opc & OPC_ALU_MASK)   == OPC_ALU_MATCH)     cls = CLS_ALU;
    else if ((opc & OPC_IMM_MASK)   == OPC_IMM_MATCH)     cls = CLS_IMM;
    else if ((opc & OPC_CMP_MASK)   == OPC_CMP_MATCH)     cls = CLS_CMP;
    else if ((opc & OPC_BR_MASK)    == OPC_BR_MATCH)      cls = CLS_BR;
    return cls;
  endfunction

endpackage

// File: rtl/stack_seq_stack_ptr.sv
// -----------------------------------------------------------------------------
// stack_ptr
//   Owns the stack pointer (SP = number of occupied slots) and evaluates the
//   overflow/underflow conditions for a candidate op combinationally, so the
//   sequencer can reject an op before any memory access is issued.
//
//   clk        : system clock
//   rst_n      : synchronous active-low reset, SP returns to 0
//   inc / dec  : advance SP after a completed push / pop (never both)
//   chk_pops   : pops requested by the candidate op (0..2)
//   chk_push   : push requested by the candidate op
//   sp         : registered stack pointer
//   underflow  : chk_pops > sp
//   overflow   : sp - chk_pops + chk_push > STACK_WORDS
// -----------------------------------------------------------------------------
module stack_ptr #(
  parameter int unsigned STACK_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           inc,
  input  logic                           dec,
  input  logic [1:0]                     chk_pops,
  input  logic                           chk_push,
  output logic [$clog2(STACK_WORDS):0]   sp,
  output logic                           underflow,
  output logic                           overflow
);

  import stack_pkg::*;

  localparam int unsigned SPW = $clog2(STACK_WORDS) + 1;
  // One extra bit so STACK_WORDS + 2 never wraps in the compare.
  localparam int unsigned CW  = SPW + 1;

  logic [CW-1:0] after_push;
  logic [CW-1:0] limit;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (inc) begin
      sp <= sp + SPW'(1);
    end else if (dec) begin
      sp <= sp - SPW'(1);
    end
  end

  // The overflow test is rearranged to sp + push > WORDS + pops so that no
  // intermediate value can go negative.
  assign after_push = CW'(sp) + CW'(chk_push);
  assign limit      = CW'(STACK_WORDS) + CW'(chk_pops);

  assign underflow  = CW'(chk_pops) > CW'(sp);
  assign overflow   = after_push > limit;

endmodule

// File: rtl/stack_seq.sv
// -----------------------------------------------------------------------------
// stack_seq
//   Multi-cycle stack-access sequencer. Takes one decoded op (pop/push bits
//   from read_reg1/read_reg2/write_reg), pops up to two operands, lets the
//   datapath settle for one cycle, then pushes the result, all through a
//   single-port memory with a req/ack handshake. Illegal ops (stack overflow
//   or underflow) are rejected at accept time with a one-cycle fault pulse
//   and no side effects.
//
//   clk, rst_n          : clock, synchronous active-low reset
//   op_valid/op_ready   : op handshake; op_ready is high only in IDLE
//   op_pop_a/op_pop_b   : pop first/second operand
//   op_push             : push the result
//   opnd_a/opnd_b       : registered popped operands
//   wb_data             : result to push, sampled when leaving EXEC
//   mem_req/mem_we      : memory request, write enable
//   mem_addr/mem_wdata  : byte address, write data (stable until ack)
//   mem_rdata/mem_ack   : read data valid with ack; ack ends the access
//   op_done             : one-cycle completion pulse
//   fault/fault_ovf     : one-cycle fault pulse; cause held (1 = overflow)
//   depth               : current stack occupancy (registered SP)
// -----------------------------------------------------------------------------
module stack_seq #(
  parameter int unsigned      ABITS       = 32,
  parameter int unsigned      DBITS       = 32,
  parameter logic [ABITS-1:0] STACK_BASE  = ABITS'(32'h0000_1000),
  parameter int unsigned      STACK_WORDS = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic                         op_pop_a,
  input  logic                         op_pop_b,
  input  logic                         op_push,
  output logic [DBITS-1:0]             opnd_a,
  output logic [DBITS-1:0]             opnd_b,
  input  logic [DBITS-1:0]             wb_data,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ABITS-1:0]             mem_addr,
  output logic [DBITS-1:0]             mem_wdata,
  input  logic [DBITS-1:0]             mem_rdata,
  input  logic                         mem_ack,
  output logic                         op_done,
  output logic                         fault,
  output logic                         fault_ovf,
  output logic [$clog2(STACK_WORDS):0] depth
);

  import stack_pkg::*;

  localparam int unsigned SPW = $clog2(STACK_WORDS) + 1;

  state_e           state;
  state_e           state_next;
  stack_req_t       req_q;
  logic [SPW-1:0]   sp;
  logic [SPW-1:0]   slot;
  logic             sp_inc;
  logic             sp_dec;
  logic             chk_under;
  logic             chk_over;
  logic             pop_a_in;
  logic             pop_b_in;
  logic [1:0]       pops_in;
  logic             accept;
  logic             legal;

  // A lone second-operand pop is folded into a first-operand pop, so the
  // first pop is "any pop" and the second needs both.
  assign pop_a_in = op_pop_a | op_pop_b;
  assign pop_b_in = op_pop_a & op_pop_b;
  assign pops_in  = {1'b0, pop_a_in} + {1'b0, pop_b_in};

  assign op_ready = (state == ST_IDLE);
  assign accept   = op_valid && op_ready;
  assign legal    = !chk_under && !chk_over;

  stack_ptr #(
    .STACK_WORDS (STACK_WORDS)
  ) u_stack_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (sp_inc),
    .dec       (sp_dec),
    .chk_pops  (pops_in),
    .chk_push  (op_push),
    .sp        (sp),
    .underflow (chk_under),
    .overflow  (chk_over)
  );

  // Next-state and access control. mem_req/mem_we/slot depend only on the
  // registered state and SP, so they are glitch-free and hold steady for the
  // whole access; mem_ack only matters in the three states that request.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    sp_inc     = 1'b0;
    sp_dec     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    slot       = '0;
    case (state)
      ST_IDLE: begin
        if (accept && legal) begin
          state_next = pop_a_in ? ST_POP_A : ST_EXEC;
        end
      end
      ST_POP_A: begin
        mem_req = 1'b1;
        slot    = sp - SPW'(1);
        if (mem_ack) begin
          sp_dec     = 1'b1;
          state_next = req_q.pop_b ? ST_POP_B : ST_EXEC;
        end
      end
      ST_POP_B: begin
        mem_req = 1'b1;
        slot    = sp - SPW'(1);
        if (mem_ack) begin
          sp_dec     = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_next = req_q.push ? ST_PUSH : ST_DONE;
      end
      ST_PUSH: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        slot    = sp;
        if (mem_ack) begin
          sp_inc     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Address is zero whenever no access is requested.
  assign mem_addr = mem_req
                  ? STACK_BASE + (ABITS'(slot) * ABITS'(WORD_BYTES))
                  : '0;

  assign op_done  = (state == ST_DONE);
  assign depth    = sp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      opnd_a    <= '0;
      opnd_b    <= '0;
      mem_wdata <= '0;
      fault     <= 1'b0;
      fault_ovf <= 1'b0;
    end else begin
      state <= state_next;
      fault <= accept && !legal;
      if (accept && !legal) begin
        // Underflow and overflow are mutually exclusive, so overflow alone
        // identifies the cause.
        fault_ovf <= chk_over;
      end
      if (accept && legal) begin
        req_q <= '{pop_b: pop_b_in, push: op_push};
      end
      if (state == ST_POP_A && mem_ack) begin
        opnd_a <= mem_rdata;
      end
      if (state == ST_POP_B && mem_ack) begin
        opnd_b <= mem_rdata;
      end
      // wb_data is only meaningful once the datapath has had the EXEC
      // cycle to settle on the freshly popped operands.
      if (state == ST_EXEC) begin
        mem_wdata <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// -----------------------------------------------------------------------------
// tb_stack_seq
//   Directed bench for stack_seq with a 4-word stack. Stimulus pushes the
//   expected memory accesses, completions and faults into a queue; a monitor
//   on the falling edge pops and compares whenever the DUT shows an ack'ed
//   access, op_done or fault. A behavioural memory with a programmable ack
//   delay stands in for the data memory.
// -----------------------------------------------------------------------------
module tb_stack_seq;

  localparam int          WORDS = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid, op_ready, op_pop_a, op_pop_b, op_push;
  logic [31:0] opnd_a, opnd_b, wb_data;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        op_done, fault, fault_ovf;
  logic [2:0]  depth;

  always #5 clk = ~clk;

  stack_seq #(
    .ABITS       (32),
    .DBITS       (32),
    .STACK_BASE  (BASE),
    .STACK_WORDS (WORDS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_pop_a  (op_pop_a),
    .op_pop_b  (op_pop_b),
    .op_push   (op_push),
    .opnd_a    (opnd_a),
    .opnd_b    (opnd_b),
    .wb_data   (wb_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .op_done   (op_done),
    .fault     (fault),
    .fault_ovf (fault_ovf),
    .depth     (depth)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem_arr [16] = '{default: 32'h0};
  int          wait_cnt = 0;
  int          cyc = 0;
  int          ack_delay = 0;
  logic        ack_force = 1'b0;
  logic        wb_sum = 1'b0;
  logic [31:0] wb_reg = 32'h0;

  function automatic int slot_of(input logic [31:0] a);
    return int'((a - BASE) >> 2) & 15;
  endfunction

  assign mem_ack   = ack_force || (mem_req && (wait_cnt >= ack_delay));
  assign mem_rdata = mem_arr[slot_of(mem_addr)];
  // The "ALU": either a fixed result or the sum of the popped operands.
  assign wb_data   = wb_sum ? (opnd_a + opnd_b) : wb_reg;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (mem_req && mem_ack && mem_we) mem_arr[slot_of(mem_addr)] <= mem_wdata;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef enum int {EV_MEM = 1, EV_DONE = 2, EV_FAULT = 3} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] a;
    logic [31:0] b;
    int          dep;
    logic        ovf;
  } ev_t;

  ev_t exp_q[$];

  // Reference model state.
  logic [31:0] mdl_mem [16] = '{default: 32'h0};
  int          mdl_sp = 0;
  logic [31:0] mdl_a = 32'h0;
  logic [31:0] mdl_b = 32'h0;
  int          acc_cyc = 0;

  function automatic ev_t mk(input ev_kind_e k, input logic we, input logic [31:0] addr,
                             input logic [31:0] data, input logic ovf);
    ev_t e;
    e.kind = k;  e.we = we;  e.addr = addr;  e.data = data;
    e.a = mdl_a; e.b = mdl_b; e.dep = mdl_sp; e.ovf = ovf;
    return e;
  endfunction

  task automatic take(input ev_kind_e k, output ev_t e, output bit ok);
    ok = 1'b0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got event kind %0d, expected none", int'(k));
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", int'(k), int'(e.kind));
      ok = (k == e.kind);
    end
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    bit  ok;
    if (rst_n) begin
      if (mem_req && mem_ack) begin
        take(EV_MEM, e, ok);
        if (ok) begin
          check("mem_addr", mem_addr, e.addr);
          check("mem_we", mem_we, e.we);
          if (e.we) check("mem_wdata", mem_wdata, e.data);
        end
      end
      if (op_done) begin
        take(EV_DONE, e, ok);
        if (ok) begin
          check("done_depth", depth, e.dep);
          check("done_opnd_a", opnd_a, e.a);
          check("done_opnd_b", opnd_b, e.b);
        end
      end
      if (fault) begin
        take(EV_FAULT, e, ok);
        if (ok) begin
          check("fault_ovf", fault_ovf, e.ovf);
          check("fault_depth", depth, e.dep);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Issue one op at a falling edge; returns at the falling edge after the
  // accepting rising edge. With track set, the expected events are queued.
  task automatic send_op(input bit pa, input bit pb, input bit ps,
                         input logic [31:0] wbv, input bit sum, input bit track);
    bit          ea, eb;
    int          pops;
    logic [31:0] res;
    ea   = pa | pb;
    eb   = pa & pb;
    pops = int'(ea) + int'(eb);
    check("ready_before_op", op_ready, 1'b1);
    if (track) begin
      if (pops > mdl_sp) begin
        exp_q.push_back(mk(EV_FAULT, 1'b0, 32'h0, 32'h0, 1'b0));
      end else if (mdl_sp - pops + int'(ps) > WORDS) begin
        exp_q.push_back(mk(EV_FAULT, 1'b0, 32'h0, 32'h0, 1'b1));
      end else begin
        if (ea) begin
          exp_q.push_back(mk(EV_MEM, 1'b0, BASE + 32'(4 * (mdl_sp - 1)), 32'h0, 1'b0));
          mdl_a = mdl_mem[mdl_sp - 1];
          mdl_sp--;
        end
        if (eb) begin
          exp_q.push_back(mk(EV_MEM, 1'b0, BASE + 32'(4 * (mdl_sp - 1)), 32'h0, 1'b0));
          mdl_b = mdl_mem[mdl_sp - 1];
          mdl_sp--;
        end
        if (ps) begin
          res = sum ? (mdl_a + mdl_b) : wbv;
          exp_q.push_back(mk(EV_MEM, 1'b1, BASE + 32'(4 * mdl_sp), res, 1'b0));
          mdl_mem[mdl_sp] = res;
          mdl_sp++;
        end
        exp_q.push_back(mk(EV_DONE, 1'b0, 32'h0, 32'h0, 1'b0));
      end
    end
    wb_reg   = wbv;
    wb_sum   = sum;
    op_pop_a = pa;
    op_pop_b = pb;
    op_push  = ps;
    op_valid = 1'b1;
    @(negedge clk);
    acc_cyc  = cyc;
    op_valid = 1'b0;
    op_pop_a = 1'b0;
    op_pop_b = 1'b0;
    op_push  = 1'b0;
  endtask

  // Wait (bounded) for op_done or fault; latency counts the accept cycle as 1.
  task automatic wait_end(input int exp_lat);
    int n;
    n = 0;
    while (!(op_done || fault) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!(op_done || fault)) begin
      checks++;
      errors++;
      $display("FAIL op_timeout: no op_done or fault within 40 cycles, expected one");
    end else if (exp_lat > 0) begin
      check("latency", cyc - acc_cyc + 1, exp_lat);
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    mdl_sp = 0;
    mdl_a  = 32'h0;
    mdl_b  = 32'h0;
  endtask

  initial begin : stim
    op_valid = 1'b0;
    op_pop_a = 1'b0;
    op_pop_b = 1'b0;
    op_push  = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_op_ready", op_ready, 1'b1);
    check("rst_depth", depth, 0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_opnd_a", opnd_a, 32'h0);
    check("rst_opnd_b", opnd_b, 32'h0);
    check("rst_done_fault", {op_done, fault, fault_ovf}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);

    // Underflow on an empty stack: fault, no access, still ready.
    send_op(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("uf_no_req", mem_req, 1'b0);
    wait_end(0);
    check("uf_ready_next", op_ready, 1'b1);
    check("uf_depth", depth, 0);
    check("uf_no_req_after", mem_req, 1'b0);

    // Single push of 0x1234.
    send_op(1'b0, 1'b0, 1'b1, 32'h1234, 1'b0, 1'b1);
    wait_end(3);
    check("push1_mem", mem_arr[0], 32'h1234);
    check("push1_depth", depth, 1);

    // Fresh stack: 5, 7, 9 then pop+pop+push of the sum.
    pulse_reset();
    send_op(1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 1'b1); wait_end(3);
    send_op(1'b0, 1'b0, 1'b1, 32'd7, 1'b0, 1'b1); wait_end(3);
    send_op(1'b0, 1'b0, 1'b1, 32'd9, 1'b0, 1'b1); wait_end(3);
    send_op(1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1); wait_end(5);
    check("add_opnd_a", opnd_a, 32'd9);
    check("add_opnd_b", opnd_b, 32'd7);
    check("add_result_mem", mem_arr[1], 32'd16);
    check("add_depth", depth, 2);

    // Fill to capacity, then overflow, then a legal pop+pop+push when full.
    send_op(1'b0, 1'b0, 1'b1, 32'h21, 1'b0, 1'b1); wait_end(3);
    send_op(1'b0, 1'b0, 1'b1, 32'h22, 1'b0, 1'b1); wait_end(3);
    check("full_depth", depth, 4);
    send_op(1'b0, 1'b0, 1'b1, 32'h99, 1'b0, 1'b1); wait_end(0);
    check("ovf_depth", depth, 4);
    check("ovf_no_write", mem_arr[4], 32'h0);
    send_op(1'b1, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1); wait_end(5);
    check("full_add_mem", mem_arr[2], 32'h43);
    check("full_add_depth", depth, 3);

    // Op with no stack traffic.
    send_op(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1); wait_end(2);
    check("nostack_depth", depth, 3);

    // Second-operand pop alone behaves as a first-operand pop.
    send_op(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1); wait_end(3);
    check("popb_only_a", opnd_a, 32'h43);
    check("popb_only_b", opnd_b, 32'h21);
    check("popb_only_depth", depth, 2);

    // Pop with the ack delayed three cycles: request held four cycles.
    ack_delay = 3;
    send_op(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("slow_req", mem_req, 1'b1);
      check("slow_addr", mem_addr, 32'h0000_1004);
      check("slow_we", mem_we, 1'b0);
      check("slow_opnd_hold", opnd_a, 32'h43);
      if (i < 3) @(negedge clk);
    end
    wait_end(6);
    check("slow_opnd_a", opnd_a, 32'd16);
    check("slow_depth", depth, 1);

    // Reset during an unacknowledged push, followed by a stray ack.
    ack_delay = 10;
    send_op(1'b0, 1'b0, 1'b1, 32'h77, 1'b0, 1'b0);
    @(negedge clk);
    check("rstmid_req", mem_req, 1'b1);
    check("rstmid_addr", mem_addr, 32'h0000_1004);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_req_dropped", mem_req, 1'b0);
    rst_n     = 1'b1;
    ack_force = 1'b1;
    mdl_sp    = 0;
    mdl_a     = 32'h0;
    mdl_b     = 32'h0;
    @(negedge clk);
    ack_force = 1'b0;
    check("rstmid_depth", depth, 0);
    check("rstmid_ready", op_ready, 1'b1);
    check("rstmid_no_req", mem_req, 1'b0);
    check("rstmid_no_write", mem_arr[1], 32'd16);

    // Normal operation resumes from an empty stack.
    ack_delay = 0;
    send_op(1'b0, 1'b0, 1'b1, 32'h55, 1'b0, 1'b1); wait_end(3);
    check("recover_mem", mem_arr[0], 32'h55);
    check("recover_depth", depth, 1);

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Multi-cycle stack-access sequencer for the stack CPU datapath.
- Accepts one decoded operation: the pop/push requirements derived from the control unit's read_reg1/read_reg2/write_reg outputs.
- Sequences up to two operand pops and one result push over a shared single-port data memory with a req/ack handshake.
- Owns the stack pointer and detects overflow/underflow before any access is issued.

Parameters:
- ABITS, 32, memory address width
- DBITS, 32, data word width
- STACK_BASE, 32'h0000_1000, byte address of stack slot 0
- STACK_WORDS, 256, stack capacity in words (power of two, >=2)

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- op_valid  input  1  decoded op offered
- op_ready  output  1  sequencer can accept an op
- op_pop_a  input  1  pop first operand (top of stack); from read_reg1
- op_pop_b  input  1  pop second operand; from read_reg2
- op_push  input  1  push result; from write_reg
- opnd_a  output  DBITS  registered first popped word
- opnd_b  output  DBITS  registered second popped word
- wb_data  input  DBITS  result from ALU/mem_to_reg/pc_to_reg mux
- mem_req  output  1  memory access request
- mem_we  output  1  1 = write
- mem_addr  output  ABITS  byte address
- mem_wdata  output  DBITS  write data
- mem_rdata  input  DBITS  read data, valid with mem_ack
- mem_ack  input  1  access complete
- op_done  output  1  one-cycle pulse on op completion (stalls PC until seen)
- fault  output  1  one-cycle pulse on overflow/underflow
- fault_ovf  output  1  registered fault cause, 1 = overflow, 0 = underflow; held until next fault
- depth  output  clog2(STACK_WORDS)+1  current stack occupancy (= SP)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-low on rst_n.
- Reset values: state IDLE, SP=0, opnd_a=opnd_b=0, op_done=0, fault=0, fault_ovf=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- States: IDLE, POP_A, POP_B, EXEC, PUSH, DONE.
- op_ready=1 only in IDLE.
- Accept: an op is accepted on an edge with op_valid and op_ready high. op_pop_a, op_pop_b and op_push are latched at acceptance.
- op_pop_b without op_pop_a is treated as op_pop_a only; pops = number of pops requested.
- Underflow check: pops > SP gives a fault pulse next cycle with fault_ovf=0. SP and memory are untouched; state stays IDLE.
- Overflow check: SP - pops + push > STACK_WORDS gives a fault pulse with fault_ovf=1, same no-side-effect rule.
- Routing after a legal accept: POP_A if a pop is requested, else EXEC.
- POP_A:
  - Drives mem_req=1, mem_we=0, mem_addr = STACK_BASE + 4*(SP-1).
  - On mem_ack: opnd_a <= mem_rdata, SP <= SP-1.
  - Next: POP_B if op_pop_b, else EXEC.
- POP_B: same as POP_A using the new SP, loading opnd_b. Next: EXEC.
- EXEC:
  - One settle cycle; the datapath computes from opnd_a/opnd_b.
  - mem_wdata <= wb_data (sampled at the edge leaving EXEC).
  - Next: PUSH if op_push, else DONE.
- PUSH:
  - Drives mem_req=1, mem_we=1, mem_addr = STACK_BASE + 4*SP, mem_wdata stable.
  - On mem_ack: SP <= SP+1. Next: DONE.
- DONE: op_done=1 for exactly one cycle, then IDLE.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until the ack cycle.
  - mem_ack may arrive in the same cycle as mem_req goes high (zero-wait memory).
  - mem_ack is ignored whenever mem_req=0.
  - mem_req deasserts the cycle after the ack.
- Latency with zero-wait memory, accept at edge T:
  - push-only: op_done high in cycle T+3.
  - pop+pop+push: op_done high in cycle T+5.
  - no-stack op: op_done high in cycle T+2.
- Address arithmetic: computed modulo 2^ABITS; the SP-1 in POP states never wraps because of the underflow check.
- Full stack (SP = STACK_WORDS) with a pop+push op is legal.
- Reset mid-operation: an outstanding request is abandoned, a late mem_ack is ignored, and SP returns to 0.
- depth is always the registered SP.

Decomposition:
- Shared package stack_pkg: state encoding enum, word size constant (4 bytes), and the opcode class constants used to derive pop/push bits: ALU 000xxx, IMM 001xxx, CMP 0100xx, BR 01100x, PUSH 100000, POP 101000, PUSH_PC 110000, POP_PC 111000.
- One natural sub-module: stack_ptr. It holds the SP register, applies inc/dec, and performs the overflow/underflow compare combinationally for the FSM.

Test Plan:
- Reset, then op_push=1, wb_data=0x1234, zero-wait memory: write to 0x1000 with data 0x1234; depth=1; op_done at accept+3.
- After three pushes of 5,7,9, op_pop_a=op_pop_b=op_push=1, wb_data=opnd_a+opnd_b: reads 0x1008 then 0x1004; opnd_a=9, opnd_b=7; write 16 to 0x1004; depth=2.
- Empty stack, op_pop_a=1: fault pulse with fault_ovf=0; no mem_req; depth=0; op_ready back high next cycle.
- STACK_WORDS=4, four pushes, then a fifth push: fault with fault_ovf=1; depth=4. Then pop+pop+push succeeds with depth=3.
- mem_ack delayed 3 cycles on a pop: mem_addr/mem_req stable all 4 cycles; opnd_a captured only on the ack; SP decrements once.
- rst_n low during PUSH before ack, then late ack: no SP change; state IDLE; depth=0; mem_req=0 the cycle after reset.
